// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the serial pattern detector.
package seq_detect_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, FILL, ARMED} state_t;

   // Width of the history fill counter; it only has to reach width-1.
   function automatic int unsigned fill_w(input int unsigned width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/shift_reg_n.sv
// Left-shifting serial-in register, updating on the falling clock edge.
module shift_reg_n #(
   parameter int unsigned W = 4
) (
   input  logic         n_clk,
   input  logic         rst,
   input  logic         en,
   input  logic         din,
   output logic [W-1:0] q
);

   always_ff @(negedge n_clk) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         q <= {q[W-2:0], din};
      end
   end

endmodule

// File: rtl/seq_detect_n.sv
// Serial pattern detector: pattern loaded MSB first on SDI, stream a compared
// against it with optional overlap, saturating match counter and sticky flag.
module seq_detect_n
   import seq_detect_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter bit          OVERLAP = 1'b1,
   parameter int unsigned CNT_W   = 8
) (
   input  logic             n_clk,
   input  logic             rst,
   input  logic             c,
   input  logic             m,
   input  logic             SDI,
   input  logic             a,
   output logic             s,
   output logic             t,
   output logic             SDO,
   output logic [CNT_W-1:0] match_count
);

   localparam int unsigned      FillW    = fill_w(WIDTH);
   localparam logic [FillW-1:0] FillLast = FillW'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CntMax   = '1;

   state_t             state_q, state_d;
   logic [FillW-1:0]   fill_q, fill_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               s_q, s_d;
   logic               t_q, t_d;
   logic [WIDTH-1:0]   pattern_q, hist_q;
   logic               pat_en, hist_en, hist_clr, match;
   logic               unused_hist_msb;

   shift_reg_n #(
      .W (WIDTH)
   ) u_pattern (
      .n_clk (n_clk),
      .rst   (rst),
      .en    (pat_en),
      .din   (SDI),
      .q     (pattern_q)
   );

   shift_reg_n #(
      .W (WIDTH)
   ) u_hist (
      .n_clk (n_clk),
      .rst   (rst | hist_clr),
      .en    (hist_en),
      .din   (a),
      .q     (hist_q)
   );

   // Only the newest WIDTH-1 history bits join the incoming bit in the compare.
   assign unused_hist_msb = hist_q[WIDTH-1];

   always_comb begin
      state_d  = state_q;
      fill_d   = fill_q;
      cnt_d    = cnt_q;
      s_d      = 1'b0;
      pat_en   = 1'b0;
      hist_en  = 1'b0;
      hist_clr = 1'b0;
      match    = 1'b0;
      if (c) begin
         if (m) begin
            pat_en  = 1'b1;
            fill_d  = '0;
            state_d = LOAD;
            if (state_q == FILL || state_q == ARMED) begin
               hist_clr = 1'b1;
            end
         end else begin
            hist_en = 1'b1;
            match   = ((state_q == ARMED) || (state_q == FILL && fill_q == FillLast)) &&
                      ({hist_q[WIDTH-2:0], a} == pattern_q);
            unique case (state_q)
               // History is already empty here, so this bit is the first one counted.
               IDLE, LOAD: begin
                  state_d = FILL;
                  fill_d  = FillW'(1);
               end
               FILL: begin
                  if (fill_q == FillLast) begin
                     state_d = ARMED;
                  end else begin
                     fill_d = fill_q + 1'b1;
                  end
               end
               ARMED: begin
               end
            endcase
            if (match && !OVERLAP) begin
               state_d = FILL;
               fill_d  = '0;
            end
            s_d = match;
            if (match && cnt_q != CntMax) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end
      t_d = t_q | (cnt_d == CntMax);
   end

   always_ff @(negedge n_clk) begin
      if (rst) begin
         state_q <= IDLE;
         fill_q  <= '0;
         cnt_q   <= '0;
         s_q     <= 1'b0;
         t_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         cnt_q   <= cnt_d;
         s_q     <= s_d;
         t_q     <= t_d;
      end
   end

   assign s           = s_q;
   assign t           = t_q;
   assign SDO         = pattern_q[WIDTH-1];
   assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_n.sv
// Bench for seq_detect_n: three configurations (overlap, non-overlap, 2-bit counter)
// driven in parallel by a directed table and by random stimulus against a window model.
module tb_seq_detect_n;

   localparam int W = 4;

   logic n_clk = 1'b0;
   always #5 n_clk = ~n_clk;

   logic rst, c, m, sdi, a;
   logic s_ov, t_ov, sdo_ov;
   logic s_no, t_no, sdo_no;
   logic s_sat, t_sat, sdo_sat;
   logic [7:0] cnt_ov, cnt_no;
   logic [1:0] cnt_sat;

   int n_tests = 0;
   int n_fail  = 0;

   seq_detect_n #(.WIDTH(W), .OVERLAP(1'b1), .CNT_W(8)) dut_ov (
      .n_clk (n_clk), .rst (rst), .c (c), .m (m), .SDI (sdi), .a (a),
      .s (s_ov), .t (t_ov), .SDO (sdo_ov), .match_count (cnt_ov)
   );

   seq_detect_n #(.WIDTH(W), .OVERLAP(1'b0), .CNT_W(8)) dut_no (
      .n_clk (n_clk), .rst (rst), .c (c), .m (m), .SDI (sdi), .a (a),
      .s (s_no), .t (t_no), .SDO (sdo_no), .match_count (cnt_no)
   );

   seq_detect_n #(.WIDTH(W), .OVERLAP(1'b1), .CNT_W(2)) dut_sat (
      .n_clk (n_clk), .rst (rst), .c (c), .m (m), .SDI (sdi), .a (a),
      .s (s_sat), .t (t_sat), .SDO (sdo_sat), .match_count (cnt_sat)
   );

   typedef struct {
      logic rst, c, m, sdi, a;
      logic sdo;
      logic s_ov;  int cnt_ov;
      logic s_no;  int cnt_no;
      logic s_sat; int cnt_sat; logic t_sat;
   } vec_t;

   vec_t vecs[$];

   // Reference model: the pattern as a number, and per configuration the bits
   // seen since the last load/reset/non-overlapped match.
   int pat;
   int winval[3];
   int winlen[3];
   int mcnt[3];
   bit mt[3];
   bit ms[3];
   int cmax[3];
   bit ovl[3];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_step(input logic r, input logic cc, input logic mm, input logic d,
                             input logic aa);
      int mask;
      bit hit;
      mask = (1 << W) - 1;
      if (r) begin
         pat = 0;
         for (int k = 0; k < 3; k++) begin
            winval[k] = 0; winlen[k] = 0; mcnt[k] = 0; mt[k] = 0; ms[k] = 0;
         end
      end else if (!cc) begin
         for (int k = 0; k < 3; k++) ms[k] = 0;
      end else if (mm) begin
         pat = ((pat << 1) | int'(d)) & mask;
         for (int k = 0; k < 3; k++) begin
            winlen[k] = 0; ms[k] = 0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            winval[k] = ((winval[k] << 1) | int'(aa)) & mask;
            if (winlen[k] < W) winlen[k]++;
            hit = (winlen[k] == W) && (winval[k] == pat);
            ms[k] = hit;
            if (hit) begin
               if (mcnt[k] < cmax[k]) mcnt[k]++;
               if (mcnt[k] == cmax[k]) mt[k] = 1;
               if (!ovl[k]) winlen[k] = 0;
            end
         end
      end
   endtask

   function automatic logic [31:0] dut_s(input int k);
      return (k == 0) ? 32'(s_ov) : (k == 1) ? 32'(s_no) : 32'(s_sat);
   endfunction
   function automatic logic [31:0] dut_t(input int k);
      return (k == 0) ? 32'(t_ov) : (k == 1) ? 32'(t_no) : 32'(t_sat);
   endfunction
   function automatic logic [31:0] dut_sdo(input int k);
      return (k == 0) ? 32'(sdo_ov) : (k == 1) ? 32'(sdo_no) : 32'(sdo_sat);
   endfunction
   function automatic logic [31:0] dut_cnt(input int k);
      return (k == 0) ? 32'(cnt_ov) : (k == 1) ? 32'(cnt_no) : 32'(cnt_sat);
   endfunction

   task automatic check_model(input string tag);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s model s[%0d]", tag, k), dut_s(k), 32'(ms[k]));
         chk($sformatf("%s model t[%0d]", tag, k), dut_t(k), 32'(mt[k]));
         chk($sformatf("%s model cnt[%0d]", tag, k), dut_cnt(k), 32'(mcnt[k]));
         chk($sformatf("%s model sdo[%0d]", tag, k), dut_sdo(k), 32'((pat >> (W - 1)) & 1));
      end
   endtask

   task automatic step(input logic r, input logic cc, input logic mm, input logic d,
                       input logic aa, input string tag);
      rst = r; c = cc; m = mm; sdi = d; a = aa;
      @(negedge n_clk);
      model_step(r, cc, mm, d, aa);
      #1;
      check_model(tag);
   endtask

   task automatic add(input logic r, input logic cc, input logic mm, input logic d,
                      input logic aa, input logic sdo, input logic s1, input int c1,
                      input logic s2, input int c2, input logic s3, input int c3,
                      input logic t3);
      vec_t v;
      v.rst = r; v.c = cc; v.m = mm; v.sdi = d; v.a = aa; v.sdo = sdo;
      v.s_ov = s1; v.cnt_ov = c1; v.s_no = s2; v.cnt_no = c2;
      v.s_sat = s3; v.cnt_sat = c3; v.t_sat = t3;
      vecs.push_back(v);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic mm;
      cmax = '{255, 255, 3};
      ovl  = '{1'b1, 1'b0, 1'b1};
      rst = 1'b1; c = 1'b0; m = 1'b0; sdi = 1'b0; a = 1'b0;

      //   rst c m sdi a  sdo  s_ov cnt  s_no cnt  s_sat cnt t
      add(1, 1, 0, 0, 0,   0,   0, 0,   0, 0,   0, 0, 0);  // reset
      add(0, 1, 1, 1, 0,   0,   0, 0,   0, 0,   0, 0, 0);  // load 1011
      add(0, 1, 1, 0, 0,   0,   0, 0,   0, 0,   0, 0, 0);
      add(0, 1, 1, 1, 0,   0,   0, 0,   0, 0,   0, 0, 0);
      add(0, 1, 1, 1, 0,   1,   0, 0,   0, 0,   0, 0, 0);
      add(0, 1, 0, 0, 1,   1,   0, 0,   0, 0,   0, 0, 0);  // stream 1011011
      add(0, 1, 0, 0, 0,   1,   0, 0,   0, 0,   0, 0, 0);
      add(0, 1, 0, 0, 1,   1,   0, 0,   0, 0,   0, 0, 0);
      add(0, 1, 0, 0, 1,   1,   1, 1,   1, 1,   1, 1, 0);
      add(0, 1, 0, 0, 0,   1,   0, 1,   0, 1,   0, 1, 0);
      add(0, 1, 0, 0, 1,   1,   0, 1,   0, 1,   0, 1, 0);
      add(0, 1, 0, 0, 1,   1,   1, 2,   0, 1,   1, 2, 0);
      add(0, 1, 0, 0, 1,   1,   0, 2,   0, 1,   0, 2, 0);  // further 1011
      add(0, 1, 0, 0, 0,   1,   0, 2,   0, 1,   0, 2, 0);
      add(0, 1, 0, 0, 1,   1,   0, 2,   0, 1,   0, 2, 0);
      add(0, 1, 0, 0, 1,   1,   1, 3,   1, 2,   1, 3, 1);
      add(0, 0, 0, 0, 0,   1,   0, 3,   0, 2,   0, 3, 1);  // c=0 hold
      add(0, 0, 0, 1, 1,   1,   0, 3,   0, 2,   0, 3, 1);
      add(0, 0, 1, 1, 0,   1,   0, 3,   0, 2,   0, 3, 1);
      add(0, 1, 0, 0, 0,   1,   0, 3,   0, 2,   0, 3, 1);
      add(0, 1, 0, 0, 1,   1,   0, 3,   0, 2,   0, 3, 1);
      add(0, 1, 0, 0, 1,   1,   1, 4,   0, 2,   1, 3, 1);  // post-saturation pulse
      add(0, 1, 1, 1, 0,   0,   0, 4,   0, 2,   0, 3, 1);  // reload 1100
      add(0, 1, 1, 1, 0,   1,   0, 4,   0, 2,   0, 3, 1);
      add(0, 1, 1, 0, 0,   1,   0, 4,   0, 2,   0, 3, 1);
      add(0, 1, 1, 0, 0,   1,   0, 4,   0, 2,   0, 3, 1);
      add(0, 1, 0, 0, 1,   1,   0, 4,   0, 2,   0, 3, 1);  // 3-bit partial: no match
      add(0, 1, 0, 0, 1,   1,   0, 4,   0, 2,   0, 3, 1);
      add(0, 1, 0, 0, 0,   1,   0, 4,   0, 2,   0, 3, 1);
      add(0, 1, 0, 0, 0,   1,   1, 5,   1, 3,   1, 3, 1);
      add(0, 1, 0, 0, 1,   1,   0, 5,   0, 3,   0, 3, 1);
      add(0, 1, 0, 0, 1,   1,   0, 5,   0, 3,   0, 3, 1);
      add(0, 1, 0, 0, 0,   1,   0, 5,   0, 3,   0, 3, 1);
      add(1, 1, 0, 0, 0,   0,   0, 0,   0, 0,   0, 0, 0);  // reset over a completing bit
      add(0, 1, 0, 0, 0,   0,   0, 0,   0, 0,   0, 0, 0);
      add(0, 1, 0, 0, 0,   0,   0, 0,   0, 0,   0, 0, 0);
      add(0, 1, 0, 0, 0,   0,   0, 0,   0, 0,   0, 0, 0);
      add(0, 1, 0, 0, 0,   0,   1, 1,   1, 1,   1, 1, 0);  // zero pattern after reset

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].c, vecs[i].m, vecs[i].sdi, vecs[i].a,
              $sformatf("vec%0d", i));
         chk($sformatf("vec%0d sdo", i), 32'(sdo_ov), 32'(vecs[i].sdo));
         chk($sformatf("vec%0d s_ov", i), 32'(s_ov), 32'(vecs[i].s_ov));
         chk($sformatf("vec%0d cnt_ov", i), 32'(cnt_ov), 32'(vecs[i].cnt_ov));
         chk($sformatf("vec%0d t_ov", i), 32'(t_ov), 32'd0);
         chk($sformatf("vec%0d s_no", i), 32'(s_no), 32'(vecs[i].s_no));
         chk($sformatf("vec%0d cnt_no", i), 32'(cnt_no), 32'(vecs[i].cnt_no));
         chk($sformatf("vec%0d s_sat", i), 32'(s_sat), 32'(vecs[i].s_sat));
         chk($sformatf("vec%0d cnt_sat", i), 32'(cnt_sat), 32'(vecs[i].cnt_sat));
         chk($sformatf("vec%0d t_sat", i), 32'(t_sat), 32'(vecs[i].t_sat));
      end

      mm = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         mm = mm ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 39) == 0);
         step(logic'($urandom_range(0, 999) == 0), logic'($urandom_range(0, 7) != 0), mm,
              logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)),
              $sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
